// File: rtl/pattern_sequencer.sv
// pattern_sequencer: selects which of the nine test patterns (3x3 grid,
// row-major, indices 0..8) the pattern generator displays. Navigation
// pulses move a pending target index. In AUTO mode the target steps through
// all nine patterns. The displayed index only takes the target's value on
// frame_start, so a pattern never changes partway through a frame.
module pattern_sequencer #(
    parameter int FRAMES_PER_STEP = 120,
    parameter int HOLDOFF_FRAMES  = 300,
    parameter int INIT_PATTERN    = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_start,
    input  logic       nav_up,
    input  logic       nav_down,
    input  logic       nav_left,
    input  logic       nav_right,
    input  logic       mode_toggle,
    output logic [3:0] pattern,
    output logic       pattern_changed,
    output logic       auto_active
);

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int HC_W = (HOLDOFF_FRAMES > 1) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

    localparam logic [3:0]      INIT_IDX  = 4'(INIT_PATTERN);
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLDOFF_FRAMES);
    localparam logic [HC_W-1:0] HOLD_ONE  = HC_W'(1);

    typedef enum logic [1:0] {
        ST_MANUAL    = 2'd0,
        ST_AUTO      = 2'd1,
        ST_AUTO_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      target_q, target_d;
    logic [3:0]      pattern_q, pattern_d;
    logic            changed_q, changed_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

    logic            nav_any;
    logic [3:0]      nav_target;

    // Grid column of an index (0..2). Out-of-range indices are unreachable.
    function automatic logic [1:0] col_of(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd3, 4'd6: col_of = 2'd0;
            4'd1, 4'd4, 4'd7: col_of = 2'd1;
            default:          col_of = 2'd2;
        endcase
    endfunction

    // Apply at most one navigation move, up > down > left > right.
    // A move that would leave the grid leaves the index unchanged.
    function automatic logic [3:0] nav_move(input logic [3:0] idx,
                                            input logic up, input logic down,
                                            input logic left, input logic right);
        nav_move = idx;
        if (up) begin
            if (idx > 4'd2) nav_move = idx - 4'd3;
        end else if (down) begin
            if (idx < 4'd6) nav_move = idx + 4'd3;
        end else if (left) begin
            if (col_of(idx) != 2'd0) nav_move = idx - 4'd1;
        end else if (right) begin
            if (col_of(idx) != 2'd2) nav_move = idx + 4'd1;
        end
    endfunction

    // Next index in the AUTO cycle, wrapping 8 back to 0.
    function automatic logic [3:0] auto_next(input logic [3:0] idx);
        auto_next = (idx == 4'd8) ? 4'd0 : idx + 4'd1;
    endfunction

    assign nav_any    = nav_up | nav_down | nav_left | nav_right;
    assign nav_target = nav_move(target_q, nav_up, nav_down, nav_left, nav_right);

    // State, target, display and counter registers; async reset to idle MANUAL.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_MANUAL;
            target_q    <= INIT_IDX;
            pattern_q   <= INIT_IDX;
            changed_q   <= 1'b0;
            frame_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            pattern_q   <= pattern_d;
            changed_q   <= changed_d;
            frame_cnt_q <= frame_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    // Next-state logic: mode transitions, nav/auto target updates, frame commit.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        pattern_d   = pattern_q;
        changed_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        hold_cnt_d  = hold_cnt_q;

        // The display always picks up the target as it stood before this
        // cycle's nav/auto update, so a same-cycle press lands next frame.
        if (frame_start) begin
            pattern_d = target_q;
            changed_d = (target_q != pattern_q);
        end

        if (nav_any) begin
            target_d = nav_target;
        end

        case (state_q)
            ST_MANUAL: begin
                frame_cnt_d = '0;
                if (mode_toggle) begin
                    if (nav_any) begin
                        state_d    = ST_AUTO_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end else begin
                        state_d = ST_AUTO;
                    end
                end
            end

            ST_AUTO: begin
                if (mode_toggle) begin
                    state_d     = ST_MANUAL;
                    hold_cnt_d  = '0;
                    frame_cnt_d = '0;
                end else if (nav_any) begin
                    // A press pauses stepping; any step due this cycle is dropped.
                    state_d     = ST_AUTO_HOLD;
                    hold_cnt_d  = HOLD_LOAD;
                    frame_cnt_d = '0;
                end else if (frame_start) begin
                    if (frame_cnt_q == FC_LAST) begin
                        frame_cnt_d = '0;
                        target_d    = auto_next(target_q);
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end

            ST_AUTO_HOLD: begin
                if (mode_toggle) begin
                    state_d     = ST_MANUAL;
                    hold_cnt_d  = '0;
                    frame_cnt_d = '0;
                end else if (nav_any) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (frame_start) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                    if (hold_cnt_q == HOLD_ONE) begin
                        state_d     = ST_AUTO;
                        frame_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d     = ST_MANUAL;
                frame_cnt_d = '0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    assign pattern         = pattern_q;
    assign pattern_changed = changed_q;
    assign auto_active     = (state_q != ST_MANUAL);

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed-vector bench for pattern_sequencer.
// Two instances share the stimulus: dut_a (FRAMES_PER_STEP=2) and
// dut_b (FRAMES_PER_STEP=1); both use HOLDOFF_FRAMES=3.
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_start = 1'b0;
    logic       nav_up = 1'b0;
    logic       nav_down = 1'b0;
    logic       nav_left = 1'b0;
    logic       nav_right = 1'b0;
    logic       mode_toggle = 1'b0;

    logic [3:0] pat_a, pat_b;
    logic       chg_a, chg_b;
    logic       auto_a, auto_b;

    int n_chk  = 0;
    int n_pass = 0;

    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

    pattern_sequencer #(
        .FRAMES_PER_STEP(2), .HOLDOFF_FRAMES(3), .INIT_PATTERN(4)
    ) dut_a (
        .clk(clk), .resetn(resetn), .frame_start(frame_start),
        .nav_up(nav_up), .nav_down(nav_down), .nav_left(nav_left),
        .nav_right(nav_right), .mode_toggle(mode_toggle),
        .pattern(pat_a), .pattern_changed(chg_a), .auto_active(auto_a)
    );

    pattern_sequencer #(
        .FRAMES_PER_STEP(1), .HOLDOFF_FRAMES(3), .INIT_PATTERN(4)
    ) dut_b (
        .clk(clk), .resetn(resetn), .frame_start(frame_start),
        .nav_up(nav_up), .nav_down(nav_down), .nav_left(nav_left),
        .nav_right(nav_right), .mode_toggle(mode_toggle),
        .pattern(pat_b), .pattern_changed(chg_b), .auto_active(auto_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic press(input int dir);
        nav_up    = (dir == UP);
        nav_down  = (dir == DOWN);
        nav_left  = (dir == LEFT);
        nav_right = (dir == RIGHT);
        cyc();
        nav_up = 1'b0; nav_down = 1'b0; nav_left = 1'b0; nav_right = 1'b0;
    endtask

    task automatic toggle();
        mode_toggle = 1'b1;
        cyc();
        mode_toggle = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(2);
    endtask

    initial begin
        int seen;
        int exp_auto[7];
        int exp_hold1[5];
        int exp_hold2[5];
        int exp_comb[5];
        exp_auto  = '{7, 7, 8, 8, 0, 0, 1};
        exp_hold1 = '{6, 6, 6, 6, 7};
        exp_hold2 = '{5, 5, 5, 5, 6};
        exp_comb  = '{4, 4, 4, 4, 5};

        // Reset state and ten idle frames
        do_reset();
        check("rst_pattern", pat_a, 4);
        check("rst_auto", auto_a, 0);
        check("rst_changed", chg_a, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            frame();
            seen = seen | chg_a | chg_b;
            idle(3);
        end
        check("idle_changed_seen", seen, 0);
        check("idle_pattern_a", pat_a, 4);
        check("idle_pattern_b", pat_b, 4);
        check("idle_auto", auto_a, 0);

        // MANUAL navigation: 4 -> right -> 5 -> right (clamped) -> commit
        press(RIGHT);
        press(RIGHT);
        check("nav_before_frame", pat_a, 4);
        frame();
        check("right_pattern", pat_a, 5);
        check("right_changed", chg_a, 1);
        cyc();
        check("changed_one_cycle", chg_a, 0);
        press(UP);
        frame();
        check("up_pattern", pat_a, 2);

        // Edge no-ops at index 0
        press(LEFT);
        press(LEFT);
        frame();
        check("to_zero", pat_a, 0);
        press(UP);
        press(LEFT);
        frame();
        check("edge_pattern", pat_a, 0);
        check("edge_changed", chg_a, 0);
        check("edge_auto", auto_a, 0);

        // AUTO with two frames per step starting at 7
        press(DOWN);
        press(DOWN);
        press(RIGHT);
        frame();
        check("auto_start", pat_a, 7);
        toggle();
        check("auto_active_on", auto_a, 1);
        for (int i = 0; i < 7; i++) begin
            frame();
            idle(2);
            check($sformatf("auto_seq[%0d]", i), pat_a, exp_auto[i]);
        end

        // Asynchronous reset mid-operation
        resetn = 1'b0;
        #1;
        check("async_rst_pattern", pat_a, 4);
        check("async_rst_auto", auto_a, 0);
        idle(1);
        resetn = 1'b1;
        idle(2);

        // Hold-off with one frame per step (dut_b)
        toggle();
        check("hold_auto_on", auto_b, 1);
        frame();
        frame();
        check("hold_prestep", pat_b, 5);
        press(LEFT);  // no-op at column 0, still pauses stepping
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("hold1[%0d]", i), pat_b, exp_hold1[i]);
            check($sformatf("hold1_auto[%0d]", i), auto_b, 1);
        end
        press(RIGHT); // no-op at index 8, enters hold
        frame();
        check("hold2_first", pat_b, 8);
        press(UP);    // during hold: 8 -> 5 and reloads the hold
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("hold2[%0d]", i), pat_b, exp_hold2[i]);
        end

        // frame_start + nav_down + mode_toggle together from MANUAL at 1
        do_reset();
        press(UP);
        frame_start = 1'b1;
        nav_down    = 1'b1;
        mode_toggle = 1'b1;
        cyc();
        frame_start = 1'b0;
        nav_down    = 1'b0;
        mode_toggle = 1'b0;
        check("comb_pattern", pat_b, 1);
        check("comb_changed", chg_b, 1);
        check("comb_auto", auto_b, 1);
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("comb_seq[%0d]", i), pat_b, exp_comb[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
